// File: rtl/adder_tree_arbiter.sv
// Round-robin front end that shares one pipelined adder tree among NUM_REQ requesters.
// Grants one vector per cycle, tags it with the requester index, and routes each returned sum to its owner.
module adder_tree_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_INPUTS = 16,
    parameter int unsigned DWIDTH     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_en,
    input  logic [NUM_REQ-1:0]                   i_req_valid,
    output logic [NUM_REQ-1:0]                   o_req_ready,
    input  logic [NUM_REQ*NUM_INPUTS*DWIDTH-1:0] i_req_vector,
    output logic [NUM_INPUTS*DWIDTH-1:0]         o_tree_vector,
    output logic                                 o_tree_valid,
    input  logic [DWIDTH-1:0]                    i_tree_sum,
    input  logic                                 i_tree_sum_valid,
    output logic [DWIDTH-1:0]                    o_rsp_sum,
    output logic [NUM_REQ-1:0]                   o_rsp_valid,
    output logic                                 o_busy,
    output logic                                 o_err
);

    localparam int unsigned NUM_STAGES = $clog2(NUM_INPUTS);
    localparam int unsigned IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned VW         = NUM_INPUTS * DWIDTH;
    // Entry 0 is loaded alongside the issue register; the rest track the tree stages.
    localparam int unsigned TAG_DEPTH  = NUM_STAGES + 1;

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] idx;
    } tag_t;

    logic [IW-1:0] r_last;
    tag_t          r_tag [TAG_DEPTH];

    logic          w_found;
    logic [IW-1:0] w_grant_idx;
    logic [IW-1:0] w_cand;
    logic          w_hs;
    logic          w_tag_any;
    tag_t          w_head;

    // Round-robin search starting just after the last winner.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            w_cand = IW'((32'(r_last) + off) % NUM_REQ);
            if (!w_found && i_req_valid[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign o_req_ready = (i_en && w_found) ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign w_hs        = |(i_req_valid & o_req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= IW'(NUM_REQ - 1);
        end else if (w_hs) begin
            r_last <= w_grant_idx;
        end
    end

    // Issue register: the tree input holds its last vector when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_tree_vector <= '0;
            o_tree_valid  <= 1'b0;
        end else begin
            o_tree_valid <= w_hs;
            if (w_hs) begin
                o_tree_vector <= i_req_vector[32'(w_grant_idx)*VW +: VW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(TAG_DEPTH); i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_hs, idx: w_grant_idx};
            for (int i = 1; i < int'(TAG_DEPTH); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_head = r_tag[TAG_DEPTH-1];

    // A sum is only accepted when it lines up with a valid tag; any disagreement is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rsp_sum   <= '0;
            o_rsp_valid <= '0;
            o_err       <= 1'b0;
        end else begin
            if (w_head.valid && i_tree_sum_valid) begin
                o_rsp_sum   <= i_tree_sum;
                o_rsp_valid <= NUM_REQ'(1) << w_head.idx;
            end else begin
                o_rsp_valid <= '0;
            end
            if (w_head.valid != i_tree_sum_valid) begin
                o_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_tag_any = 1'b0;
        for (int i = 0; i < int'(TAG_DEPTH); i++) begin
            w_tag_any = w_tag_any | r_tag[i].valid;
        end
    end

    assign o_busy = o_tree_valid | w_tag_any | (|o_rsp_valid);

endmodule
